burst_line_ctrl: RTL and testbench

- Initiator-side controller for the team's burst RAM command interface (cmd/cmd_en/addr/wr_data/rd_data/rd_data_valid/busy).
- Accepts whole-line read or write requests from a client (cache or CPU fetch unit) and sequences the BURST_COUNT-beat transfers.
- Assembles read beats into a line register and returns it with a single response pulse.
- Sits between client logic and the RAM IP, or its simulation model.

---
 rtl/burst_ctrl_pkg.sv | 22 ++
 rtl/burst_line_buffer.sv | 47 ++++
 rtl/burst_line_ctrl.sv | 158 +++++++++++++++
 tb/tb_burst_line_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ctrl_pkg.sv
// Shared definitions for the burst RAM line controller.
// One-hot state encoding and RAM command codes (also used by the RAM model).
package burst_ctrl_pkg;

    localparam int ST_IDLE_B = 0;
    localparam int ST_ISSUE_B = 1;
    localparam int ST_WR_B = 2;
    localparam int ST_RD_B = 3;
    localparam int ST_RESP_B = 4;

    typedef enum logic [4:0] {
        ST_IDLE       = 5'b00001,
        ST_ISSUE      = 5'b00010,
        ST_WR_BURST   = 5'b00100,
        ST_RD_COLLECT = 5'b01000,
        ST_RESP       = 5'b10000
    } state_t;

    localparam logic CMD_READ = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_line_buffer.sv
// Line buffer: whole-line load with beat read mux for write sequencing,
// beat-indexed collection for reads, committed into a stable response line.
module burst_line_buffer #(
    parameter int DATA_BITWIDTH = 64,
    parameter int BURST_COUNT   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_load,
    input  logic [BURST_COUNT*DATA_BITWIDTH-1:0]   i_load_line,
    input  logic [$clog2(BURST_COUNT)-1:0]         i_rd_idx,
    output logic [DATA_BITWIDTH-1:0]               o_rd_beat,
    input  logic                                   i_beat_we,
    input  logic                                   i_commit,
    input  logic [$clog2(BURST_COUNT)-1:0]         i_beat_idx,
    input  logic [DATA_BITWIDTH-1:0]               i_beat_data,
    output logic [BURST_COUNT*DATA_BITWIDTH-1:0]   o_line
);

    logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] r_tx;
    logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] r_rx;
    logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] r_line;
    logic [BURST_COUNT-1:0][DATA_BITWIDTH-1:0] w_merged;

    assign o_rd_beat = r_tx[i_rd_idx];
    assign o_line = r_line;

    // Final beat is merged in so the response line updates in one step.
    always_comb begin
        w_merged = r_rx;
        w_merged[i_beat_idx] = i_beat_data;
    end

    // Capture outgoing line, incoming beats and the completed read line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= '0;
            r_rx <= '0;
            r_line <= '0;
        end else begin
            if (i_load) r_tx <= i_load_line;
            if (i_beat_we) r_rx[i_beat_idx] <= i_beat_data;
            if (i_beat_we && i_commit) r_line <= w_merged;
        end
    end

endmodule

// File: rtl/burst_line_ctrl.sv
// Whole-line read/write sequencer for the burst RAM command interface.
// Optional read watchdog: define BURST_LINE_CTRL_TIMEOUT_EN.
module burst_line_ctrl
    import burst_ctrl_pkg::*;
#(
    parameter int ADDR_BITWIDTH  = 4,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic                                           req_write,
    input  logic [ADDR_BITWIDTH-$clog2(BURST_COUNT)-1:0]   req_line_addr,
    input  logic [BURST_COUNT*DATA_BITWIDTH-1:0]           req_wr_line,
    output logic                                           rsp_valid,
    output logic [BURST_COUNT*DATA_BITWIDTH-1:0]           rsp_rd_line,
    output logic                                           rsp_err,
    output logic                                           ram_cmd,
    output logic                                           ram_cmd_en,
    output logic [ADDR_BITWIDTH-1:0]                       ram_addr,
    output logic [DATA_BITWIDTH-1:0]                       ram_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]                     ram_data_mask,
    input  logic [DATA_BITWIDTH-1:0]                       ram_rd_data,
    input  logic                                           ram_rd_data_valid,
    input  logic                                           ram_busy
);

    localparam int CNT_W = $clog2(BURST_COUNT);
    localparam int LINE_AW = ADDR_BITWIDTH - CNT_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_COUNT - 1);

    if (BURST_COUNT < 2 || (BURST_COUNT & (BURST_COUNT - 1)) != 0) begin : g_bad_bc
        $error("BURST_COUNT must be a power of two >= 2");
    end
    if (DATA_BITWIDTH % 8 != 0) begin : g_bad_dw
        $error("DATA_BITWIDTH must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_cmd;
    logic [LINE_AW-1:0]   r_line_addr;
    logic                 w_accept;
    logic                 w_beat_we;
    logic                 w_last;
    logic                 w_timeout;

    assign req_ready = r_state[ST_IDLE_B] & ~rst;
    assign w_accept = req_valid & req_ready;
    assign ram_cmd_en = r_state[ST_ISSUE_B] & ~ram_busy & ~rst;
    assign rsp_valid = r_state[ST_RESP_B] & ~rst;
    assign ram_cmd = r_cmd;
    assign ram_addr = {r_line_addr, {CNT_W{1'b0}}};
    assign ram_data_mask = '0;
    assign w_beat_we = r_state[ST_RD_B] & ram_rd_data_valid;
    assign w_last = (r_cnt == LAST_BEAT);

`ifdef BURST_LINE_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;

    assign w_timeout = r_state[ST_RD_B] & ~ram_rd_data_valid
                     & (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err = r_err & ~rst;

    // Idle-cycle watchdog while collecting read beats.
    always_ff @(posedge clk) begin
        if (rst || !r_state[ST_RD_B] || ram_rd_data_valid) r_to_cnt <= '0;
        else r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Error flag lives exactly for the RESP cycle of an aborted read.
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
        else if (r_state[ST_RESP_B]) r_err <= 1'b0;
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // Request sequencing: IDLE -> ISSUE -> WR_BURST/RD_COLLECT -> RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt <= '0;
            r_cmd <= CMD_READ;
            r_line_addr <= '0;
        end else begin
            unique case (1'b1)
                r_state[ST_IDLE_B]: begin
                    if (w_accept) begin
                        r_cmd <= req_write ? CMD_WRITE : CMD_READ;
                        r_line_addr <= req_line_addr;
                        r_state <= ST_ISSUE;
                    end
                end
                r_state[ST_ISSUE_B]: begin
                    if (!ram_busy) begin
                        if (r_cmd == CMD_WRITE) begin
                            r_cnt <= CNT_W'(1);
                            r_state <= ST_WR_BURST;
                        end else begin
                            r_cnt <= '0;
                            r_state <= ST_RD_COLLECT;
                        end
                    end
                end
                r_state[ST_WR_B]: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= ST_RESP;
                end
                r_state[ST_RD_B]: begin
                    if (w_timeout) begin
                        r_cnt <= '0;
                        r_state <= ST_RESP;
                    end else if (ram_rd_data_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) r_state <= ST_RESP;
                    end
                end
                r_state[ST_RESP_B]: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    burst_line_buffer #(
        .DATA_BITWIDTH (DATA_BITWIDTH),
        .BURST_COUNT   (BURST_COUNT)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept & req_write),
        .i_load_line (req_wr_line),
        .i_rd_idx    (r_cnt),
        .o_rd_beat   (ram_wr_data),
        .i_beat_we   (w_beat_we),
        .i_commit    (w_last),
        .i_beat_idx  (r_cnt),
        .i_beat_data (ram_rd_data),
        .o_line      (rsp_rd_line)
    );

endmodule

// File: tb/tb_burst_line_ctrl.sv
// Self-checking bench for burst_line_ctrl with a behavioural burst RAM.
// Define BURST_LINE_CTRL_TIMEOUT_EN to also exercise the read watchdog.
module tb_burst_line_ctrl;
    import burst_ctrl_pkg::*;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int BC = 4;
    localparam int TO = 16;
    localparam int RAM_INIT = 10;
    localparam int RAM_DELAY = 8;

    typedef logic [BC*DW-1:0] line_t;

    typedef struct {
        bit          wr;
        logic [1:0]  ln;
        line_t       wl;
        line_t       exp_rd;
        logic [3:0]  exp_addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic req_write = 1'b0;
    logic [1:0] req_line_addr = '0;
    line_t req_wr_line = '0;
    logic rsp_valid;
    line_t rsp_rd_line;
    logic rsp_err;
    logic ram_cmd;
    logic ram_cmd_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW/8-1:0] ram_data_mask;
    logic [DW-1:0] ram_rd_data = '0;
    logic ram_rd_data_valid = 1'b0;
    logic ram_busy = 1'b1;

    burst_line_ctrl #(
        .ADDR_BITWIDTH  (AW),
        .DATA_BITWIDTH  (DW),
        .BURST_COUNT    (BC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_line_addr     (req_line_addr),
        .req_wr_line       (req_wr_line),
        .rsp_valid         (rsp_valid),
        .rsp_rd_line       (rsp_rd_line),
        .rsp_err           (rsp_err),
        .ram_cmd           (ram_cmd),
        .ram_cmd_en        (ram_cmd_en),
        .ram_addr          (ram_addr),
        .ram_wr_data       (ram_wr_data),
        .ram_data_mask     (ram_data_mask),
        .ram_rd_data       (ram_rd_data),
        .ram_rd_data_valid (ram_rd_data_valid),
        .ram_busy          (ram_busy)
    );

    always #5 clk = ~clk;

    // Behavioural burst RAM: calibration window, fixed read delay, optional gaps.
    logic [DW-1:0] mem [16];
    int init_cnt = 0;
    int wr_ptr = 0, wr_left = 0;
    int rd_ptr = 0, rd_left = 0, rd_wait = 0;
    bit gaps = 0, stub = 0, stray_req = 0;
    logic [DW-1:0] stray_data = '0;

    always @(posedge clk) begin
        ram_rd_data_valid <= 1'b0;
        if (init_cnt < RAM_INIT) init_cnt++;
        if (wr_left > 0) begin
            mem[wr_ptr] = ram_wr_data;
            wr_ptr++;
            wr_left--;
        end
        if (rd_left > 0) begin
            if (rd_wait > 0) rd_wait--;
            else if (!(gaps && $urandom_range(0, 2) == 0)) begin
                ram_rd_data <= mem[rd_ptr];
                ram_rd_data_valid <= 1'b1;
                rd_ptr++;
                rd_left--;
            end
        end
        if (stray_req) begin
            ram_rd_data <= stray_data;
            ram_rd_data_valid <= 1'b1;
            stray_req = 0;
        end
        if (ram_cmd_en && !ram_busy) begin
            if (ram_cmd == CMD_WRITE) begin
                mem[ram_addr] = ram_wr_data;
                wr_ptr = int'(ram_addr) + 1;
                wr_left = BC - 1;
            end else if (!stub) begin
                rd_ptr = int'(ram_addr);
                rd_left = BC;
                rd_wait = RAM_DELAY - 1;
            end
        end
        ram_busy <= (init_cnt < RAM_INIT) || wr_left > 0 || rd_left > 0;
    end

    // Event monitor sampled on the falling edge.
    int cyc = 0, n_cmd = 0, n_rsp = 0, n_beats = 0, n_viol = 0;
    int cmd_cyc = 0, rsp_cyc = 0;
    logic [AW-1:0] cmd_addr = '0;
    logic cmd_wr = 1'b0;
    line_t rsp_line = '0;
    logic rsp_e = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (ram_cmd_en) begin
            n_cmd++;
            cmd_addr = ram_addr;
            cmd_wr = ram_cmd;
            cmd_cyc = cyc;
            if (ram_busy) n_viol++;
        end
        if (rsp_valid) begin
            n_rsp++;
            rsp_line = rsp_rd_line;
            rsp_e = rsp_err;
            rsp_cyc = cyc;
        end
        if (ram_rd_data_valid) n_beats++;
    end

    int n_checks = 0;
    int n_fail = 0;
    line_t exp_line [4];

    task automatic chk(input string name, input line_t act, input line_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic line_t ram_line(input int ln);
        line_t r;
        for (int b = 0; b < BC; b++) r[b*DW +: DW] = mem[ln*BC + b];
        return r;
    endfunction

    // One request: wait for acceptance, then for exactly one response.
    task automatic do_req(input bit wr, input logic [1:0] ln, input line_t wl,
                          output int acc);
        int r0, c0;
        bit ok;
        #1;
        r0 = n_rsp;
        c0 = n_cmd;
        req_valid = 1'b1;
        req_write = wr;
        req_line_addr = ln;
        req_wr_line = wl;
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready) begin
                acc = cyc;
                break;
            end
            tick();
        end
        chk("accepted", line_t'(acc >= 0), 1);
        tick();
        req_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (n_rsp != r0) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk("rsp_seen", line_t'(ok), 1);
        tick();
        tick();
        chk("rsp_once", line_t'(n_rsp - r0), 1);
        chk("cmd_once", line_t'(n_cmd - c0), 1);
    endtask

    vec_t tbl [6];
    line_t A, B, C, L0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, r0, c0, b0, first_rsp;
        bit wr;
        logic [1:0] ln;
        line_t wl;

        for (int i = 0; i < 16; i++) mem[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
        for (int l = 0; l < 4; l++)
            for (int b = 0; b < BC; b++)
                exp_line[l][b*DW +: DW] = 64'hA5A5_0000_0000_0000 + 64'(l*BC + b);

        A = {64'h4444444444444444, 64'h3333333333333333,
             64'h2222222222222222, 64'h1111111111111111};
        B = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
             64'hDEADBEEFCAFEF00D, 64'h0F0F0F0FF0F0F0F0};
        C = {64'hC3C3C3C3C3C3C3C3, 64'h5A5A5A5A5A5A5A5A,
             64'h0000FFFF0000FFFF, 64'h1234123412341234};
        L0 = {64'hA5A5000000000003, 64'hA5A5000000000002,
              64'hA5A5000000000001, 64'hA5A5000000000000};
        tbl[0] = '{1, 2'd1, A, '0, 4'd4};
        tbl[1] = '{0, 2'd1, '0, A, 4'd4};
        tbl[2] = '{1, 2'd2, B, '0, 4'd8};
        tbl[3] = '{0, 2'd2, '0, B, 4'd8};
        tbl[4] = '{0, 2'd0, '0, L0, 4'd0};
        tbl[5] = '{0, 2'd1, '0, A, 4'd4};

        // Reset with a write request already pending.
        rst = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_line_addr = 2'd1;
        req_wr_line = A;
        repeat (3) tick();
        chk("rst_req_ready", line_t'(req_ready), 0);
        chk("rst_rsp_valid", line_t'(rsp_valid), 0);
        chk("rst_rsp_err", line_t'(rsp_err), 0);
        chk("rst_rsp_line", rsp_rd_line, 0);
        chk("rst_cmd_en", line_t'(ram_cmd_en), 0);
        chk("rst_cmd", line_t'(ram_cmd), 0);
        rst = 1'b0;

        // Table-driven transfers; row 0 is the held-from-reset write.
        for (int i = 0; i < 6; i++) begin
            do_req(tbl[i].wr, tbl[i].ln, tbl[i].wl, acc);
            chk("cmd_addr", line_t'(cmd_addr), line_t'(tbl[i].exp_addr));
            chk("cmd_kind", line_t'(cmd_wr), line_t'(tbl[i].wr));
            chk("rsp_err", line_t'(rsp_e), 0);
            if (tbl[i].wr) begin
                exp_line[tbl[i].ln] = tbl[i].wl;
                chk("ram_words", ram_line(tbl[i].ln), tbl[i].wl);
                if (i == 0) chk("cmd_after_cal", line_t'(cmd_cyc >= RAM_INIT), 1);
                else chk("wr_latency", line_t'(rsp_cyc - acc), BC + 1);
            end else begin
                chk("rd_line", rsp_line, tbl[i].exp_rd);
            end
        end

        // Back-to-back: write line 3 then read it with req_valid held.
        #1;
        c0 = n_cmd;
        r0 = n_rsp;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_line_addr = 2'd3;
        req_wr_line = C;
        for (int i = 0; i < 100 && !req_ready; i++) tick();
        tick();
        req_write = 1'b0;
        first_rsp = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (n_rsp > r0 && first_rsp < 0) first_rsp = rsp_cyc;
            if (first_rsp >= 0 && req_valid && req_ready) begin
                tick();
                req_valid = 1'b0;
            end
            if (n_rsp - r0 >= 2) break;
        end
        req_valid = 1'b0;
        repeat (2) tick();
        exp_line[3] = C;
        chk("b2b_rsp_count", line_t'(n_rsp - r0), 2);
        chk("b2b_cmd_count", line_t'(n_cmd - c0), 2);
        chk("b2b_cmd_after_resp", line_t'(first_rsp >= 0 && cmd_cyc > first_rsp), 1);
        chk("b2b_rd_line", rsp_line, C);
        chk("b2b_ram_words", ram_line(3), C);

        // Randomized traffic with gapped read beats against the line model.
        gaps = 1;
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(0, 1));
            ln = 2'($urandom_range(0, 3));
            for (int b = 0; b < BC*DW/32; b++) wl[b*32 +: 32] = $urandom;
            do_req(wr, ln, wl, acc);
            chk("rnd_cmd_addr", line_t'(cmd_addr), line_t'({ln, 2'b00}));
            chk("rnd_err", line_t'(rsp_e), 0);
            if (wr) begin
                exp_line[ln] = wl;
                chk("rnd_ram_words", ram_line(int'(ln)), wl);
                chk("rnd_wr_latency", line_t'(rsp_cyc - acc), BC + 1);
            end else begin
                chk("rnd_rd_line", rsp_line, exp_line[ln]);
            end
        end
        gaps = 0;

        // Reset two beats into a read of line 2.
        r0 = n_rsp;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_line_addr = 2'd2;
        for (int i = 0; i < 100 && !req_ready; i++) tick();
        tick();
        req_valid = 1'b0;
        b0 = n_beats;
        for (int i = 0; i < 100 && (n_beats - b0) < 2; i++) tick();
        chk("mid_rd_beats", line_t'(n_beats - b0), 2);
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", line_t'(req_ready), 0);
        chk("mid_rst_rsp_valid", line_t'(rsp_valid), 0);
        chk("mid_rst_line", rsp_rd_line, 0);
        chk("mid_rst_cmd_en", line_t'(ram_cmd_en), 0);
        rst = 1'b0;
        repeat (20) tick();
        chk("mid_rst_no_rsp", line_t'(n_rsp - r0), 0);
        do_req(0, 2'd0, '0, acc);
        chk("post_rst_rd_line", rsp_line, exp_line[0]);

        // Stray read-valid while idle must be ignored.
        r0 = n_rsp;
        c0 = n_cmd;
        stray_data = 64'hBADD_BADD_BADD_BADD;
        stray_req = 1;
        repeat (3) tick();
        chk("stray_ready", line_t'(req_ready), 1);
        chk("stray_line", rsp_rd_line, exp_line[0]);
        chk("stray_no_rsp", line_t'(n_rsp - r0), 0);
        chk("stray_no_cmd", line_t'(n_cmd - c0), 0);
        do_req(0, 2'd3, '0, acc);
        chk("post_stray_rd", rsp_line, exp_line[3]);

`ifdef BURST_LINE_CTRL_TIMEOUT_EN
        // RAM never answers: watchdog aborts with an error response.
        stub = 1;
        do_req(0, 2'd1, '0, acc);
        chk("to_err", line_t'(rsp_e), 1);
        chk("to_delay", line_t'(rsp_cyc - (cmd_cyc + 1)), TO);
        stub = 0;
        do_req(0, 2'd1, '0, acc);
        chk("post_to_rd", rsp_line, exp_line[1]);
        chk("post_to_err", line_t'(rsp_e), 0);
`endif

        chk("cmd_while_busy", line_t'(n_viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
